// File: rtl/vec_seq_pkg.sv
// Shared encodings for the vector-op sequencer: op field, ALU control and FSM states.
package vec_seq_pkg;

   typedef enum logic [1:0] {
      OP_ILL  = 2'b00,
      OP_DOT  = 2'b01,
      OP_SMUL = 2'b10,
      OP_VADD = 2'b11
   } vec_op_e;

   typedef enum logic [1:0] {
      ALU_NONE = 2'b00,
      ALU_MAC  = 2'b01,
      ALU_MUL  = 2'b10,
      ALU_ADD  = 2'b11
   } alu_op_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLR,
      S_ELEM,
      S_WB,
      S_DONE
   } seq_state_e;

   function automatic alu_op_e op_to_alu(input vec_op_e op);
      case (op)
         OP_DOT:  return ALU_MAC;
         OP_SMUL: return ALU_MUL;
         OP_VADD: return ALU_ADD;
         default: return ALU_NONE;
      endcase
   endfunction

endpackage

// File: rtl/vec_addr_gen.sv
// Element address generator: base + idx*stride, wrapping silently at 2^REG_ADDR_W.
module vec_addr_gen
   import vec_seq_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = 4,
   parameter int unsigned CNT_W      = 3
) (
   input  logic [REG_ADDR_W-1:0] base,
   input  logic [CNT_W-1:0]      idx,
   input  logic [REG_ADDR_W-1:0] stride,
   output logic [REG_ADDR_W-1:0] addr
);

   // Truncating idx before the multiply is exact because only the low bits survive the wrap.
   always_comb begin
      addr = base + (REG_ADDR_W'(idx) * stride);
   end

endmodule

// File: rtl/vec_op_sequencer.sv
// Vector-instruction sequencer: steps one element per cycle through dot product,
// vector*scalar and vector add, driving register-file and accumulator controls.
// Optional build macro VEC_SEQ_STRIDE_EN adds a latched element stride input.
module vec_op_sequencer
   import vec_seq_pkg::*;
#(
   parameter int unsigned VLEN       = 5,
   parameter int unsigned NUM_REGS   = 16,
   parameter int unsigned REG_ADDR_W = 4,
   parameter int unsigned CNT_W      = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic                  zero_acc,
   input  logic [REG_ADDR_W-1:0] rd_base,
   input  logic [REG_ADDR_W-1:0] rn_base,
   input  logic [REG_ADDR_W-1:0] rm_base,
   input  logic                  stall,
   input  logic                  abort,
`ifdef VEC_SEQ_STRIDE_EN
   input  logic [REG_ADDR_W-1:0] stride,
`endif
   output logic                  busy,
   output logic                  done,
   output logic                  illegal,
   output logic [REG_ADDR_W-1:0] rf_ra,
   output logic [REG_ADDR_W-1:0] rf_rb,
   output logic [REG_ADDR_W-1:0] rf_wa,
   output logic                  rf_we,
   output logic                  wb_sel,
   output logic [1:0]            alu_op,
   output logic                  acc_clr,
   output logic                  acc_en,
   output logic [CNT_W-1:0]      elem_idx
);

   localparam logic [CNT_W-1:0]      LAST_IDX  = CNT_W'(VLEN - 1);
   localparam logic [REG_ADDR_W-1:0] ADDR_MASK = REG_ADDR_W'(NUM_REGS - 1);

   seq_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  accept;
   vec_op_e               op_q;
   logic [REG_ADDR_W-1:0] rd_q, rn_q, rm_q;
   logic [REG_ADDR_W-1:0] stride_q;
   logic [REG_ADDR_W-1:0] rb_stride;
   logic [REG_ADDR_W-1:0] ra_addr, rb_addr, wa_addr;

   // Capture the instruction fields when a start is accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q <= OP_ILL;
         rd_q <= '0;
         rn_q <= '0;
         rm_q <= '0;
`ifdef VEC_SEQ_STRIDE_EN
         stride_q <= '0;
`endif
      end else if (accept) begin
         op_q <= vec_op_e'(op);
         rd_q <= rd_base;
         rn_q <= rn_base;
         rm_q <= rm_base;
`ifdef VEC_SEQ_STRIDE_EN
         stride_q <= stride;
`endif
      end
   end

`ifndef VEC_SEQ_STRIDE_EN
   assign stride_q = REG_ADDR_W'(1);
`endif

   // The scalar operand of vector*scalar never advances.
   assign rb_stride = (op_q == OP_SMUL) ? '0 : stride_q;

   vec_addr_gen #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) u_ra_gen (
      .base(rn_q), .idx(cnt_q), .stride(stride_q), .addr(ra_addr)
   );
   vec_addr_gen #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) u_rb_gen (
      .base(rm_q), .idx(cnt_q), .stride(rb_stride), .addr(rb_addr)
   );
   vec_addr_gen #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) u_wa_gen (
      .base(rd_q), .idx(cnt_q), .stride(stride_q), .addr(wa_addr)
   );

   // State and element counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, counter and output decode; abort outranks everything but reset.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      accept   = 1'b0;
      busy     = (state_q != S_IDLE);
      done     = 1'b0;
      illegal  = 1'b0;
      rf_ra    = '0;
      rf_rb    = '0;
      rf_wa    = '0;
      rf_we    = 1'b0;
      wb_sel   = 1'b0;
      alu_op   = ALU_NONE;
      acc_clr  = 1'b0;
      acc_en   = 1'b0;
      elem_idx = cnt_q;

      if (abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  accept = 1'b1;
                  cnt_d  = '0;
                  case (vec_op_e'(op))
                     OP_ILL:  state_d = S_DONE;
                     OP_DOT:  state_d = zero_acc ? S_CLR : S_ELEM;
                     default: state_d = S_ELEM;
                  endcase
               end
            end
            S_CLR:  state_d = S_ELEM;
            S_ELEM: begin
               if (!stall) begin
                  if (cnt_q == LAST_IDX) begin
                     cnt_d   = '0;
                     state_d = (op_q == OP_DOT) ? S_WB : S_DONE;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            S_WB:   state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end

      case (state_q)
         S_CLR: acc_clr = !abort;
         S_ELEM: begin
            rf_ra  = ra_addr & ADDR_MASK;
            rf_rb  = rb_addr & ADDR_MASK;
            alu_op = op_to_alu(op_q);
            if (op_q == OP_DOT) begin
               acc_en = !stall && !abort;
            end else begin
               rf_wa = wa_addr & ADDR_MASK;
               rf_we = !stall && !abort;
            end
         end
         S_WB: begin
            rf_wa  = rd_q;
            rf_we  = !abort;
            wb_sel = 1'b1;
         end
         S_DONE: begin
            done    = !abort;
            illegal = !abort && (op_q == OP_ILL);
         end
         default: ;
      endcase
   end

endmodule
